seq_divider: RTL and testbench

//  Multi-cycle signed restoring divider; the inverse of the datapath multiplier (2W product -> W operands).

---
 rtl/arith_pkg.sv | 37 +++
 rtl/div_step.sv | 23 ++
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: FSM state encoding, a width helper and the
// magnitude/sign functions used by the divider and the multiplier wrappers.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Widest operand the magnitude helpers handle; callers zero-extend into
  // this width and truncate the result back to their own width.
  localparam int MAG_W = 64;

  // Bits needed to hold the values 0 .. n-1 (never less than 1).
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Two's-complement negate when neg is set. The low bits of the result are
  // correct for any narrower operand, whatever its extension.
  function automatic logic [MAG_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + 64'd1) : mag;
  endfunction

  // Magnitude of a two's-complement value whose sign bit is passed in.
  // The most negative value maps onto its own bit pattern, which read as
  // unsigned is exactly its magnitude.
  function automatic logic [MAG_W-1:0] abs_val(input logic [MAG_W-1:0] val,
                                               input logic             neg);
    return apply_sign(val, neg);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor magnitude if it fits.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_out,
  output logic         quo_bit
);

  logic [W:0] shifted;

  // The shifted remainder is below 2*|divisor|, so after a successful
  // subtraction the result fits W bits and plain low-bit arithmetic is exact.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    quo_bit = (shifted >= {1'b0, dvsr});
    rem_out = quo_bit ? (shifted[W-1:0] - dvsr) : shifted[W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: 2W-bit dividend by W-bit divisor,
// truncating toward zero, with a start/busy/done handshake.
//
// Handshake: start is sampled only while idle (busy=0); the accepting edge
// captures dividend and divisor, after which they may change freely. done
// pulses for exactly one cycle, the first idle cycle, and a start in that
// same cycle is accepted. Results and flags hold until the next completion.
module seq_divider
  import arith_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*IN_WIDTH-1:0] dividend,
  input  logic [IN_WIDTH-1:0]   divisor,
  output logic [2*IN_WIDTH-1:0] quotient,
  output logic [IN_WIDTH-1:0]   remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int W  = IN_WIDTH;
  localparam int DW = 2 * IN_WIDTH;
  localparam int CW = clog2(DW);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   quo_r;      // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]    rem_r;      // partial remainder magnitude
  logic [W-1:0]    dvsr_r;     // divisor magnitude
  logic            neg_q;
  logic            neg_r;
  logic            dvsr_zero;

  logic [W-1:0]    step_rem;
  logic            step_bit;
  logic [DW-1:0]   fix_q;
  logic [W-1:0]    fix_r;

  div_step #(.W(W)) u_step (
    .rem_in       (rem_r),
    .dividend_bit (quo_r[DW-1]),
    .dvsr         (dvsr_r),
    .rem_out      (step_rem),
    .quo_bit      (step_bit)
  );

  assign busy = (state != ST_IDLE);

  // State register; reset always wins over a same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: one accepted start runs 2W CALC steps, then a single FIX cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start)     state_next = ST_CALC;
      ST_CALC: if (cnt == '0) state_next = ST_FIX;
      ST_FIX:                 state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Operand capture on the accepting edge, then one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      dvsr_r    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvsr_zero <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            quo_r     <= DW'(abs_val(64'(dividend), dividend[DW-1]));
            dvsr_r    <= W'(abs_val(64'(divisor), divisor[W-1]));
            neg_q     <= dividend[DW-1] ^ divisor[W-1];
            neg_r     <= dividend[DW-1];
            dvsr_zero <= (divisor == '0);
            rem_r     <= '0;
            cnt       <= CW'(DW - 1);
          end
        end
        ST_CALC: begin
          rem_r <= step_rem;
          quo_r <= {quo_r[DW-2:0], step_bit};
          cnt   <= cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Signed results from the magnitudes: quotient takes the XOR of the operand
  // signs, remainder takes the dividend sign (truncation toward zero).
  always_comb begin
    fix_q = DW'(apply_sign(64'(quo_r), neg_q));
    fix_r = W'(apply_sign(64'(rem_r), neg_r));
  end

  // Result and flag registers, loaded only in FIX so they hold between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_FIX) begin
        done <= 1'b1;
        if (dvsr_zero) begin
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
        end else begin
          quotient    <= fix_q;
          remainder   <= fix_r;
          div_by_zero <= 1'b0;
          // A positive quotient with the top magnitude bit set cannot be
          // represented; only -2^(2W-1) / -1 reaches this, and the result wraps.
          overflow    <= ~neg_q & quo_r[DW-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (IN_WIDTH=8): latency, sign handling,
// divide-by-zero, overflow, ignored starts, back-to-back and mid-op reset.
module tb_seq_divider;

  localparam int W  = 8;
  localparam int DW = 16;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [DW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic [DW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic busy, done, div_by_zero, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_divider #(.IN_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Sign/boundary table: dividend, divisor, expected quotient, expected remainder
  logic [DW-1:0] sg_dd [7] = '{-16'sd100, 16'sd100, -16'sd100, 16'sd0, 16'sd1000, -16'sd7, 16'h8000};
  logic [W-1:0]  sg_dv [7] = '{8'sd7, -8'sd7, -8'sd7, 8'sd5, 8'h80, 8'h80, 8'h80};
  logic [DW-1:0] sg_q  [7] = '{-16'sd14, -16'sd14, 16'sd14, 16'sd0, -16'sd7, 16'sd0, 16'sd256};
  logic [W-1:0]  sg_r  [7] = '{-8'sd2, 8'sd2, -8'sd2, 8'sd0, 8'sd104, -8'sd7, 8'sd0};

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the operand inputs.
  task automatic start_op(input logic [DW-1:0] dd, input logic [W-1:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = 16'($urandom_range(0, 65535));
    divisor  = 8'($urandom_range(0, 255));
  endtask

  // Cycles from the accepting edge to done (0 if it never comes within 40),
  // plus the number of sampled cycles with busy high before done.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    step();
    step();
    n_checks++;
    if (quotient !== 16'd0) $display("FAIL reset_quotient: got %h want 0000", quotient);
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd0) $display("FAIL reset_remainder: got %h want 00", remainder);
    else n_pass++;
    n_checks++;
    if ({busy, done, div_by_zero, overflow} !== 4'b0000)
      $display("FAIL reset_flags: busy/done/dbz/ovf got %b want 0000", {busy, done, div_by_zero, overflow});
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    start_op(16'd100, 8'd7);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 17) $display("FAIL basic_latency: got %0d want 17", lat);
    else n_pass++;
    n_checks++;
    if (bc !== 17) $display("FAIL basic_busy_cycles: got %0d want 17", bc);
    else n_pass++;
    n_checks++;
    if (quotient !== 16'd14) $display("FAIL basic_quotient: got %0d want 14", $signed(quotient));
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd2) $display("FAIL basic_remainder: got %0d want 2", $signed(remainder));
    else n_pass++;
    n_checks++;
    if ({div_by_zero, overflow} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {div_by_zero, overflow});
    else n_pass++;
    step();
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_one_cycle: got %b want 0", done);
    else n_pass++;
    n_checks++;
    if (quotient !== 16'd14) $display("FAIL basic_quotient_held: got %0d want 14", $signed(quotient));
    else n_pass++;
  endtask

  task automatic test_signs();
    int lat, bc;
    for (int k = 0; k < 7; k++) begin
      start_op(sg_dd[k], sg_dv[k]);
      wait_done(lat, bc);
      n_checks++;
      if (quotient !== sg_q[k])
        $display("FAIL signs_quotient[%0d]: got %0d want %0d", k, $signed(quotient), $signed(sg_q[k]));
      else n_pass++;
      n_checks++;
      if (remainder !== sg_r[k])
        $display("FAIL signs_remainder[%0d]: got %0d want %0d", k, $signed(remainder), $signed(sg_r[k]));
      else n_pass++;
      n_checks++;
      if ({div_by_zero, overflow} !== 2'b00)
        $display("FAIL signs_flags[%0d]: got %b want 00", k, {div_by_zero, overflow});
      else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    start_op(16'd1234, 8'd0);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 17) $display("FAIL dbz_latency: got %0d want 17", lat);
    else n_pass++;
    n_checks++;
    if (quotient !== 16'd0) $display("FAIL dbz_quotient: got %h want 0000", quotient);
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd0) $display("FAIL dbz_remainder: got %h want 00", remainder);
    else n_pass++;
    n_checks++;
    if ({div_by_zero, overflow} !== 2'b10) $display("FAIL dbz_flags: got %b want 10", {div_by_zero, overflow});
    else n_pass++;
    start_op(16'd50, 8'd5);
    wait_done(lat, bc);
    n_checks++;
    if (quotient !== 16'd10) $display("FAIL dbz_next_quotient: got %0d want 10", $signed(quotient));
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd0) $display("FAIL dbz_next_remainder: got %0d want 0", $signed(remainder));
    else n_pass++;
    n_checks++;
    if ({div_by_zero, overflow} !== 2'b00) $display("FAIL dbz_next_flags: got %b want 00", {div_by_zero, overflow});
    else n_pass++;
  endtask

  task automatic test_overflow();
    int lat, bc;
    start_op(16'h8000, 8'hFF);
    wait_done(lat, bc);
    n_checks++;
    if (quotient !== 16'h8000) $display("FAIL ovf_quotient: got %h want 8000", quotient);
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd0) $display("FAIL ovf_remainder: got %h want 00", remainder);
    else n_pass++;
    n_checks++;
    if ({div_by_zero, overflow} !== 2'b01) $display("FAIL ovf_flags: got %b want 01", {div_by_zero, overflow});
    else n_pass++;
    start_op(16'h7FFF, 8'd1);
    wait_done(lat, bc);
    n_checks++;
    if (quotient !== 16'h7FFF) $display("FAIL maxpos_quotient: got %h want 7fff", quotient);
    else n_pass++;
    n_checks++;
    if ({div_by_zero, overflow} !== 2'b00) $display("FAIL maxpos_flags: got %b want 00", {div_by_zero, overflow});
    else n_pass++;
    start_op(16'h8000, 8'd1);
    wait_done(lat, bc);
    n_checks++;
    if (quotient !== 16'h8000) $display("FAIL minneg_quotient: got %h want 8000", quotient);
    else n_pass++;
    n_checks++;
    if ({div_by_zero, overflow} !== 2'b00) $display("FAIL minneg_flags: got %b want 00", {div_by_zero, overflow});
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int n_done, done_cyc;
    logic [DW-1:0] got_q;
    logic [W-1:0]  got_r;
    n_done = 0;
    done_cyc = 0;
    got_q = '0;
    got_r = '0;
    start_op(16'd500, 8'd3);
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 9) begin
        start = 1'b1;
        dividend = 16'd1;
        divisor = 8'd1;
      end
      step();
      start = 1'b0;
      if (done) begin
        n_done++;
        done_cyc = c;
        got_q = quotient;
        got_r = remainder;
      end
    end
    n_checks++;
    if (n_done !== 1) $display("FAIL ignore_done_count: got %0d want 1", n_done);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 17) $display("FAIL ignore_done_cycle: got %0d want 17", done_cyc);
    else n_pass++;
    n_checks++;
    if (got_q !== 16'd166) $display("FAIL ignore_quotient: got %0d want 166", $signed(got_q));
    else n_pass++;
    n_checks++;
    if (got_r !== 8'd2) $display("FAIL ignore_remainder: got %0d want 2", $signed(got_r));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_op(16'd77, 8'd4);
    wait_done(lat, bc);
    n_checks++;
    if ({quotient, remainder} !== {16'd19, 8'd1})
      $display("FAIL b2b_first: got q=%0d r=%0d want q=19 r=1", $signed(quotient), $signed(remainder));
    else n_pass++;
    // Still in the done cycle: the next start must be accepted here.
    start_op(16'd200, -8'sd9);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 17) $display("FAIL b2b_latency: got %0d want 17", lat);
    else n_pass++;
    n_checks++;
    if (bc !== 17) $display("FAIL b2b_busy_cycles: got %0d want 17", bc);
    else n_pass++;
    n_checks++;
    if (quotient !== -16'sd22) $display("FAIL b2b_quotient: got %0d want -22", $signed(quotient));
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd2) $display("FAIL b2b_remainder: got %0d want 2", $signed(remainder));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bc, n_done;
    start_op(16'd1000, 8'd3);
    repeat (4) step();
    rst = 1'b1;
    start = 1'b1;
    dividend = 16'd5;
    divisor = 8'd1;
    step();
    rst = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL rstmid_busy_done: got %b want 00", {busy, done});
    else n_pass++;
    n_checks++;
    if ({quotient, remainder} !== 24'd0)
      $display("FAIL rstmid_outputs: got q=%h r=%h want 0", quotient, remainder);
    else n_pass++;
    n_done = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (done) n_done++;
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d done pulses want 0", n_done);
    else n_pass++;
    start_op(16'd9, 8'd2);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 17) $display("FAIL rstmid_next_latency: got %0d want 17", lat);
    else n_pass++;
    n_checks++;
    if (quotient !== 16'd4) $display("FAIL rstmid_next_quotient: got %0d want 4", $signed(quotient));
    else n_pass++;
    n_checks++;
    if (remainder !== 8'd1) $display("FAIL rstmid_next_remainder: got %0d want 1", $signed(remainder));
    else n_pass++;
  endtask

  // final report
  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
